// File: rtl/ad9361_pkt_pkg.sv
// Shared types and header layout for the AD9361 AXI-stream packetizer.
package ad9361_pkt_pkg;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned TS_W   = 48;

    localparam logic [15:0] HDR_MAGIC = 16'hAD93;

    localparam int unsigned HDR_MAGIC_LSB = 112;
    localparam int unsigned HDR_LEN_LSB   = 96;
    localparam int unsigned HDR_SEQ_LSB   = 64;
    localparam int unsigned HDR_DROP_LSB  = 48;
    localparam int unsigned HDR_TS_LSB    = 0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHeader  = 2'd1,
        StPayload = 2'd2
    } pkt_state_e;

    function automatic logic [DATA_W-1:0] build_header(
        input logic [15:0]     len,
        input logic [31:0]     seq,
        input logic [15:0]     drops,
        input logic [TS_W-1:0] ts
    );
        logic [DATA_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
        hdr[HDR_LEN_LSB +: 16]   = len;
        hdr[HDR_SEQ_LSB +: 32]   = seq;
        hdr[HDR_DROP_LSB +: 16]  = drops;
        hdr[HDR_TS_LSB +: TS_W]  = ts;
        return hdr;
    endfunction

endpackage

// File: rtl/ad9361_pkt_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data_o shows the head entry whenever not empty.
module ad9361_pkt_fifo #(
    parameter int unsigned Width = 128,
    parameter int unsigned Depth = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [Width-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [Width-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] DepthCount = Depth[AddrW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             wr_fire;
    logic             rd_fire;

    assign full_o    = (count_q == DepthCount);
    assign empty_o   = (count_q == '0);
    assign wr_fire   = wr_en_i & ~full_o;
    assign rd_fire   = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ad9361_axis_packetizer.sv
// Frames the free-running AD9361 IQ stream into header + payload packets.
// Optional header timestamp: define AD9361_PKT_TIMESTAMP_EN.
module ad9361_axis_packetizer
    import ad9361_pkt_pkg::*;
#(
    parameter int unsigned PAYLOAD_WORDS = 256,
    parameter int unsigned FIFO_DEPTH    = 1024
) (
    input  logic              axis_clk,
    input  logic              axis_rst,
    input  logic              enable,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LevelW-1:0] PayloadLevel = LevelW'(PAYLOAD_WORDS);
    localparam logic [15:0] PayloadLen = 16'(PAYLOAD_WORDS);
    localparam logic [15:0] LastBeat   = 16'(PAYLOAD_WORDS - 1);

    logic              fifo_wr;
    logic              fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LevelW-1:0] fifo_level;
    logic [DATA_W-1:0] fifo_rdata;
    logic              drop;
    logic              start_ok;
    logic              hs;
    logic              hdr_ack;
    logic [TS_W-1:0]   ts_field;
    logic [DATA_W-1:0] hdr_word;
    logic [15:0]       drop_base;

    pkt_state_e        state_q, state_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [15:0]       beat_q, beat_d;
    logic [31:0]       seq_q, seq_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [15:0]       snap_q, snap_d;
    logic              overflow_q;
    logic              tready_q;

    assign fifo_wr  = s_axis_tvalid & enable & ~fifo_full;
    assign drop     = s_axis_tvalid & enable & fifo_full;
    assign start_ok = enable & (fifo_level >= PayloadLevel);
    assign hs       = tvalid_q & m_axis_tready;

    ad9361_pkt_fifo #(
        .Width (DATA_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (axis_clk),
        .rst_i     (axis_rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (s_axis_tdata),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

`ifdef AD9361_PKT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign ts_field = ts_q;
`else
    assign ts_field = '0;
`endif

    assign hdr_word = build_header(PayloadLen, seq_q, drop_cnt_q, ts_field);

    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        beat_d   = beat_q;
        seq_d    = seq_q;
        snap_d   = snap_q;
        fifo_rd  = 1'b0;
        hdr_ack  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d  = StHeader;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = hdr_word;
                    snap_d   = drop_cnt_q;
                end
            end
            StHeader: begin
                if (hs) begin
                    state_d = StPayload;
                    tdata_d = fifo_rdata;
                    tlast_d = 1'b0;
                    fifo_rd = ~fifo_empty;
                    beat_d  = '0;
                    seq_d   = seq_q + 32'd1;
                    hdr_ack = 1'b1;
                end
            end
            StPayload: begin
                if (hs) begin
                    if (beat_q == LastBeat) begin
                        if (start_ok) begin
                            state_d  = StHeader;
                            tvalid_d = 1'b1;
                            tlast_d  = 1'b0;
                            tdata_d  = hdr_word;
                            snap_d   = drop_cnt_q;
                        end else begin
                            state_d  = StIdle;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        beat_d  = beat_q + 16'd1;
                        tdata_d = fifo_rdata;
                        tlast_d = ((beat_q + 16'd1) == LastBeat);
                        fifo_rd = ~fifo_empty;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    // Drops landing after the header was latched are carried into the next header.
    always_comb begin
        drop_base  = hdr_ack ? (drop_cnt_q - snap_q) : drop_cnt_q;
        drop_cnt_d = drop_base;
        if (drop && (drop_base != 16'hFFFF)) begin
            drop_cnt_d = drop_base + 16'd1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q    <= StIdle;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            beat_q     <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            snap_q     <= '0;
            overflow_q <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            beat_q     <= beat_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            snap_q     <= snap_d;
            overflow_q <= overflow_q | drop;
            tready_q   <= 1'b1;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_ad9361_axis_packetizer.sv
// Directed bench for ad9361_axis_packetizer with PAYLOAD_WORDS=4, FIFO_DEPTH=8.
module tb_ad9361_axis_packetizer;

    localparam int unsigned PW = 4;
    localparam int unsigned FD = 8;

`ifdef AD9361_PKT_TIMESTAMP_EN
    localparam logic [127:0] HdrMask = {80'hFFFF_FFFF_FFFF_FFFF_FFFF, 48'h0};
`else
    localparam logic [127:0] HdrMask = {128{1'b1}};
`endif

    logic         axis_clk = 1'b0;
    logic         axis_rst;
    logic         enable;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [127:0] s_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [127:0] m_axis_tdata;
    logic         overflow;
    logic [15:0]  drop_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_feed = 0;
    int rst_tick = 0;

    logic [127:0] q_data[$];
    logic         q_last[$];
    int           q_tick[$];

    logic         chk_stable = 1'b0;
    logic         stall_prev = 1'b0;
    logic [127:0] hold_data = '0;
    logic         hold_last = 1'b0;

    always #5 axis_clk = ~axis_clk;

    ad9361_axis_packetizer #(
        .PAYLOAD_WORDS (PW),
        .FIFO_DEPTH    (FD)
    ) dut (
        .axis_clk      (axis_clk),
        .axis_rst      (axis_rst),
        .enable        (enable),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    function automatic logic [127:0] exp_hdr(input logic [31:0] seq, input logic [15:0] drops);
        return {16'hAD93, 16'd4, seq, drops, 48'h0};
    endfunction

    function automatic logic [127:0] qd(input int i);
        if (i < q_data.size()) return q_data[i];
        return 'x;
    endfunction

    function automatic logic ql(input int i);
        if (i < q_last.size()) return q_last[i];
        return 1'bx;
    endfunction

    function automatic int qt(input int i);
        if (i < q_tick.size()) return q_tick[i];
        return -1000;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge axis_clk);
        if (chk_stable && stall_prev) begin
            check("stable_tdata", m_axis_tdata, hold_data);
            check("stable_tlast", {127'd0, m_axis_tlast}, {127'd0, hold_last});
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        hold_data  = m_axis_tdata;
        hold_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_last.push_back(m_axis_tlast);
            q_tick.push_back(cyc);
        end
        @(posedge axis_clk);
        #1;
        cyc++;
    endtask

    task automatic feed(input logic [127:0] d);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        last_feed     = cyc;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_tick.delete();
    endtask

    task automatic do_reset();
        axis_rst      = 1'b1;
        s_axis_tvalid = 1'b0;
        tick();
        rst_tick = cyc - 1;
        axis_rst = 1'b0;
        tick();
        clear_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_rst      = 1'b1;
        enable        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
        check("rst_tlast", {127'd0, m_axis_tlast}, 128'd0);
        check("rst_tdata", m_axis_tdata, 128'd0);
        check("rst_s_tready", {127'd0, s_axis_tready}, 128'd0);
        check("rst_overflow", {127'd0, overflow}, 128'd0);
        check("rst_drop", {112'd0, drop_count}, 128'd0);
        axis_rst = 1'b0;
        tick();
        check("s_tready_up", {127'd0, s_axis_tready}, 128'd1);

        // Basic packet
        clear_q();
        enable        = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 4; i++) feed(128'(i));
        idle(12);
        check("basic_len", 128'(q_data.size()), 128'd5);
        check("basic_hdr", qd(0) & HdrMask, exp_hdr(32'd0, 16'd0));
`ifndef AD9361_PKT_TIMESTAMP_EN
        check("basic_ts_zero", {80'd0, qd(0)[47:0]}, 128'd0);
`endif
        check("basic_hdr_latency", 128'(qt(0) - last_feed), 128'd2);
        for (int i = 1; i <= 4; i++) begin
            check("basic_payload", qd(i), 128'(i));
            check("basic_tlast", {127'd0, ql(i)}, (i == 4) ? 128'd1 : 128'd0);
        end
        check("basic_hdr_tlast", {127'd0, ql(0)}, 128'd0);

        // Continuous stream: three packets, back to back
        do_reset();
        enable        = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 12; i++) feed(128'h100 + 128'(i));
        idle(20);
        check("cont_len", 128'(q_data.size()), 128'd15);
        for (int p = 0; p < 3; p++) begin
            check("cont_hdr", qd(p * 5) & HdrMask, exp_hdr(32'(p), 16'd0));
            for (int k = 0; k < 4; k++) begin
                check("cont_payload", qd(p * 5 + 1 + k), 128'h100 + 128'(p * 4 + k));
            end
            check("cont_tlast", {127'd0, ql(p * 5 + 4)}, 128'd1);
        end
        check("cont_gap1", 128'(qt(5) - qt(4)), 128'd1);
        check("cont_gap2", 128'(qt(10) - qt(9)), 128'd1);

        // Overflow: 11 beats into 8 entries with output stalled
        do_reset();
        enable        = 1'b1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 11; i++) feed(128'h200 + 128'(i));
        check("ovf_flag", {127'd0, overflow}, 128'd1);
        check("ovf_drop", {112'd0, drop_count}, 128'd3);
        check("ovf_pending_hdr", m_axis_tdata & HdrMask, exp_hdr(32'd0, 16'd0));
        m_axis_tready = 1'b1;
        idle(20);
        check("ovf_len", 128'(q_data.size()), 128'd10);
        check("ovf_hdr2", qd(5) & HdrMask, exp_hdr(32'd1, 16'd3));
        check("ovf_p1_first", qd(1), 128'h200);
        check("ovf_p2_last", qd(9), 128'h207);
        check("ovf_drop_after", {112'd0, drop_count}, 128'd0);
        check("ovf_sticky", {127'd0, overflow}, 128'd1);

        // Back-pressure: tready toggles, outputs must hold while stalled
        do_reset();
        enable     = 1'b1;
        stall_prev = 1'b0;
        chk_stable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            m_axis_tready = i[0];
            if (i < 4) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = 128'h300 + 128'(i);
            end else begin
                s_axis_tvalid = 1'b0;
            end
            tick();
        end
        chk_stable = 1'b0;
        check("bp_len", 128'(q_data.size()), 128'd5);
        check("bp_hdr", qd(0) & HdrMask, exp_hdr(32'd0, 16'd0));
        for (int k = 0; k < 4; k++) check("bp_payload", qd(1 + k), 128'h300 + 128'(k));
        check("bp_tlast", {127'd0, ql(4)}, 128'd1);
        check("bp_mid_tlast", {127'd0, ql(3)}, 128'd0);

        // Enable low mid-packet
        do_reset();
        enable        = 1'b1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) feed(128'h400 + 128'(i));
        m_axis_tready = 1'b1;
        for (int b = 0; b < 30 && q_data.size() < 3; b++) tick();
        enable        = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 128'h500;
        for (int i = 0; i < 20; i++) tick();
        s_axis_tvalid = 1'b0;
        check("en_len", 128'(q_data.size()), 128'd5);
        check("en_last_word", qd(4), 128'h403);
        check("en_tlast", {127'd0, ql(4)}, 128'd1);
        check("en_no_ovf", {127'd0, overflow}, 128'd0);
        enable = 1'b1;
        idle(20);
        check("en_len2", 128'(q_data.size()), 128'd10);
        check("en_hdr2", qd(5) & HdrMask, exp_hdr(32'd1, 16'd0));
        for (int k = 0; k < 4; k++) check("en_payload2", qd(6 + k), 128'h404 + 128'(k));

        // Reset mid-packet
        do_reset();
        enable        = 1'b1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) feed(128'h600 + 128'(i));
        check("mr_ovf_set", {127'd0, overflow}, 128'd1);
        m_axis_tready = 1'b1;
        for (int b = 0; b < 30 && q_data.size() < 3; b++) tick();
        axis_rst = 1'b1;
        tick();
        rst_tick = cyc - 1;
        axis_rst = 1'b0;
        check("mr_tvalid", {127'd0, m_axis_tvalid}, 128'd0);
        check("mr_overflow", {127'd0, overflow}, 128'd0);
        check("mr_drop", {112'd0, drop_count}, 128'd0);
        clear_q();
        for (int i = 0; i < 4; i++) feed(128'h700 + 128'(i));
        idle(15);
        check("mr_len", 128'(q_data.size()), 128'd5);
        check("mr_hdr", qd(0) & HdrMask, exp_hdr(32'd0, 16'd0));
        for (int k = 0; k < 4; k++) check("mr_payload", qd(1 + k), 128'h700 + 128'(k));
`ifdef AD9361_PKT_TIMESTAMP_EN
        check("mr_ts", {80'd0, qd(0)[47:0]}, 128'(qt(0) - rst_tick - 2));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
